// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: round-robin arbitration of trace sources into a
// circular trace RAM with an arm/trigger/post-trigger window and oldest-first readout.
module trace_capture_ctrl #(
    parameter int unsigned Fpay  = 32,
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SW    = 2,
    parameter int unsigned AW    = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    trig,
    input  logic [AW:0]             post_count,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*Fpay-1:0]   src_data,
    output logic [N_SRC-1:0]        src_ack,
    output logic                    tb_wr_en,
    output logic [AW-1:0]           tb_wr_addr,
    output logic [SW+Fpay-1:0]      tb_din,
    output logic                    tb_rd_en,
    output logic [AW-1:0]           tb_rd_addr,
    input  logic [SW+Fpay-1:0]      tb_rd_data,
    input  logic                    rd_req,
    output logic                    rd_valid,
    output logic [SW+Fpay-1:0]      rd_data,
    output logic                    rd_empty,
    output logic [1:0]              state,
    output logic                    wrapped
);

    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(1) << AW;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          cur, nxt;
    logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [AW:0]     rd_cnt, rd_cnt_nxt;
    logic [AW:0]     post_rem, post_rem_nxt;
    logic [SW-1:0]   last_grant, last_grant_nxt;
    logic            wrapped_nxt;
    logic            rd_valid_nxt;
    logic [SW-1:0]   gnt, cand;
    logic            found;
    logic            write_ok;
    logic [Fpay-1:0] src_word [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_split
        assign src_word[i] = src_data[i*Fpay +: Fpay];
    end

    assign state    = cur;
    // Read data is only meaningful in the cycle after a RAM read strobe.
    assign rd_data  = rd_valid ? tb_rd_data : '0;
    assign rd_empty = (cur == DONE) && (rd_cnt == '0) && !rd_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur        <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            post_rem   <= '0;
            last_grant <= SW'(N_SRC - 1);
            wrapped    <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            cur        <= nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            rd_cnt     <= rd_cnt_nxt;
            post_rem   <= post_rem_nxt;
            last_grant <= last_grant_nxt;
            wrapped    <= wrapped_nxt;
            rd_valid   <= rd_valid_nxt;
        end
    end

    // Next-state, arbitration and RAM strobes
    always_comb begin
        nxt            = cur;
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        rd_cnt_nxt     = rd_cnt;
        post_rem_nxt   = post_rem;
        last_grant_nxt = last_grant;
        wrapped_nxt    = wrapped;
        rd_valid_nxt   = 1'b0;
        src_ack        = '0;
        tb_wr_en       = 1'b0;
        tb_wr_addr     = wr_ptr;
        tb_din         = '0;
        tb_rd_en       = 1'b0;
        tb_rd_addr     = rd_ptr;
        gnt            = last_grant;
        cand           = '0;
        found          = 1'b0;

        // Round-robin search starting just after the last granted source.
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = SW'((32'(last_grant) + k) % N_SRC);
            if (!found && src_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end

        write_ok = (cur == ARMED) || ((cur == POST) && (post_rem != '0));
        if (write_ok && found) begin
            src_ack        = N_SRC'(1) << gnt;
            tb_wr_en       = 1'b1;
            tb_din         = {gnt, src_word[gnt]};
            last_grant_nxt = gnt;
            wr_ptr_nxt     = wr_ptr + AW'(1);
            if (wr_ptr == LAST_ADDR)
                wrapped_nxt = 1'b1;
            if (cur == POST)
                post_rem_nxt = post_rem - (AW+1)'(1);
        end

        case (cur)
            IDLE: begin
                if (arm) begin
                    nxt          = ARMED;
                    wr_ptr_nxt   = '0;
                    wrapped_nxt  = 1'b0;
                    post_rem_nxt = post_count;
                end
            end
            ARMED: begin
                if (trig)
                    nxt = POST;
            end
            POST: begin
                // Oldest entry sits at wr_ptr once the buffer has wrapped.
                if (post_rem == '0) begin
                    nxt        = DONE;
                    rd_ptr_nxt = wrapped ? wr_ptr : '0;
                    rd_cnt_nxt = wrapped ? CNT_FULL : {1'b0, wr_ptr};
                end
            end
            DONE: begin
                if (rd_req && (rd_cnt != '0)) begin
                    tb_rd_en   = 1'b1;
                    rd_ptr_nxt = rd_ptr + AW'(1);
                    rd_cnt_nxt = rd_cnt - (AW+1)'(1);
                end
                if (arm) begin
                    nxt          = ARMED;
                    wr_ptr_nxt   = '0;
                    wrapped_nxt  = 1'b0;
                    post_rem_nxt = post_count;
                end
            end
            default: ;
        endcase

        rd_valid_nxt = tb_rd_en;
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl (AW=4) with a registered-read RAM model.
module tb_trace_capture_ctrl;

    localparam int unsigned FP  = 32;
    localparam int unsigned NS  = 4;
    localparam int unsigned SWD = 2;
    localparam int unsigned AWD = 4;
    localparam int unsigned DW  = SWD + FP;

    logic              clk;
    logic              reset;
    logic              arm;
    logic              trig;
    logic [AWD:0]      post_count;
    logic [NS-1:0]     src_valid;
    logic [NS*FP-1:0]  src_data;
    logic [NS-1:0]     src_ack;
    logic              tb_wr_en;
    logic [AWD-1:0]    tb_wr_addr;
    logic [DW-1:0]     tb_din;
    logic              tb_rd_en;
    logic [AWD-1:0]    tb_rd_addr;
    logic [DW-1:0]     tb_rd_data;
    logic              rd_req;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              rd_empty;
    logic [1:0]        state;
    logic              wrapped;

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [DW-1:0] mem    [16];
    logic [DW-1:0] shadow [16];

    trace_capture_ctrl #(.Fpay(FP), .N_SRC(NS), .SW(SWD), .AW(AWD)) dut (
        .clk(clk), .reset(reset), .arm(arm), .trig(trig), .post_count(post_count),
        .src_valid(src_valid), .src_data(src_data), .src_ack(src_ack),
        .tb_wr_en(tb_wr_en), .tb_wr_addr(tb_wr_addr), .tb_din(tb_din),
        .tb_rd_en(tb_rd_en), .tb_rd_addr(tb_rd_addr), .tb_rd_data(tb_rd_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_empty(rd_empty),
        .state(state), .wrapped(wrapped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Trace RAM: single write port, registered read.
    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_addr] <= tb_din;
        if (tb_rd_en) tb_rd_data <= mem[tb_rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic a, input logic t, input logic [3:0] v, input logic rq);
        @(negedge clk);
        arm = a; trig = t; src_valid = v; rd_req = rq;
        n++;
        for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = {4'(i), 28'(n)};
        #1;
    endtask

    function automatic logic [DW-1:0] word(input int g);
        return {2'(g), 4'(g), 28'(n)};
    endfunction

    task automatic exp_wr(input string tag, input int g, input int addr);
        chk({tag, "_wr_en"}, 64'(tb_wr_en), 64'(1));
        chk({tag, "_ack"},   64'(src_ack), 64'(1) << g);
        chk({tag, "_addr"},  64'(tb_wr_addr), 64'(addr));
        chk({tag, "_din"},   64'(tb_din), 64'(word(g)));
        shadow[addr] = word(g);
    endtask

    task automatic read_all(input string tag, input int start, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            drive(0, 0, 4'h0, 1);
            chk({tag, "_rd_en"},   64'(tb_rd_en), 64'(1));
            chk({tag, "_rd_addr"}, 64'(tb_rd_addr), 64'((start + k) % 16));
            chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(k != 0));
            if (k != 0)
                chk({tag, "_rd_data"}, 64'(rd_data), 64'(shadow[(start + k - 1) % 16]));
        end
        drive(0, 0, 4'h0, 1);
        chk({tag, "_last_valid"}, 64'(rd_valid), 64'(1));
        chk({tag, "_last_data"},  64'(rd_data), 64'(shadow[(start + cnt - 1) % 16]));
        chk({tag, "_no_rd_en"},   64'(tb_rd_en), 64'(0));
        chk({tag, "_not_empty"},  64'(rd_empty), 64'(0));
        drive(0, 0, 4'h0, 1);
        chk({tag, "_extra_valid"}, 64'(rd_valid), 64'(0));
        chk({tag, "_empty"},       64'(rd_empty), 64'(1));
        chk({tag, "_extra_rd_en"}, 64'(tb_rd_en), 64'(0));
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig = 1'b0; post_count = '0;
        src_valid = 4'hF; src_data = '0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state",    64'(state), 64'(0));
        chk("rst_wrapped",  64'(wrapped), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_data",  64'(rd_data), 64'(0));
        chk("rst_wr_en",    64'(tb_wr_en), 64'(0));
        chk("rst_ack",      64'(src_ack), 64'(0));
        chk("rst_rd_en",    64'(tb_rd_en), 64'(0));
        chk("rst_empty",    64'(rd_empty), 64'(0));
        reset = 1'b0;

        // Arm and trig together from IDLE: arm wins. Then all four sources valid.
        post_count = 0;
        drive(1, 1, 4'h0, 0);
        chk("idle_state", 64'(state), 64'(0));
        for (int j = 0; j < 8; j++) begin
            drive(0, 0, 4'hF, 0);
            if (j == 0) chk("armed_not_post", 64'(state), 64'(1));
            exp_wr("rr4", j % 4, j);
        end
        drive(0, 1, 4'h0, 0);
        chk("trig_cycle_state", 64'(state), 64'(1));
        chk("trig_cycle_no_wr", 64'(tb_wr_en), 64'(0));
        drive(0, 0, 4'hF, 0);
        chk("post0_state", 64'(state), 64'(2));
        chk("post0_no_wr", 64'(tb_wr_en), 64'(0));
        chk("post0_no_ack", 64'(src_ack), 64'(0));
        drive(0, 0, 4'h0, 0);
        chk("done1_state", 64'(state), 64'(3));
        chk("done1_wrapped", 64'(wrapped), 64'(0));
        chk("done1_not_empty", 64'(rd_empty), 64'(0));
        read_all("rd1", 0, 8);
        drive(0, 1, 4'h0, 0);
        drive(0, 0, 4'h0, 0);
        chk("done_trig_ignored", 64'(state), 64'(3));

        // Re-arm from DONE with post_count=3, sources 0 and 2 only.
        post_count = 3;
        drive(1, 0, 4'h0, 0);
        chk("rearm_cycle_state", 64'(state), 64'(3));
        for (int j = 0; j < 5; j++) begin
            drive(0, 0, 4'b0101, 0);
            if (j == 0) begin
                chk("rearm_state", 64'(state), 64'(1));
                chk("rearm_wrapped", 64'(wrapped), 64'(0));
            end
            exp_wr("rr2", (j % 2 != 0) ? 2 : 0, j);
        end
        drive(0, 1, 4'h0, 0);
        chk("trig2_no_wr", 64'(tb_wr_en), 64'(0));
        for (int j = 5; j < 8; j++) begin
            drive(0, 0, 4'b0101, 0);
            chk("post3_state", 64'(state), 64'(2));
            exp_wr("post3", (j % 2 != 0) ? 2 : 0, j);
        end
        drive(0, 0, 4'b0101, 0);
        chk("post3_end_state", 64'(state), 64'(2));
        chk("post3_end_no_wr", 64'(tb_wr_en), 64'(0));
        drive(0, 0, 4'h0, 0);
        chk("done2_state", 64'(state), 64'(3));
        chk("done2_wrapped", 64'(wrapped), 64'(0));
        read_all("rd2", 0, 8);

        // Wrap: 20 writes into a 16-entry buffer, readout from oldest (addr 4).
        post_count = 0;
        drive(1, 0, 4'h0, 0);
        for (int j = 0; j < 20; j++) begin
            drive(0, 0, 4'hF, 0);
            chk("wrap_flag", 64'(wrapped), 64'(j > 15));
            exp_wr("wrap", (3 + j) % 4, j % 16);
        end
        drive(0, 1, 4'h0, 0);
        drive(0, 0, 4'h0, 0);
        chk("wrap_post_state", 64'(state), 64'(2));
        drive(0, 0, 4'h0, 0);
        chk("wrap_done_state", 64'(state), 64'(3));
        chk("wrap_done_flag", 64'(wrapped), 64'(1));
        read_all("rd3", 4, 16);

        // Reset in POST with two post-trigger writes still pending.
        post_count = 2;
        drive(1, 0, 4'h0, 0);
        drive(0, 1, 4'h0, 0);
        chk("rst_seq_armed", 64'(state), 64'(1));
        drive(0, 0, 4'hF, 0);
        chk("rst_seq_post", 64'(state), 64'(2));
        chk("rst_seq_wr_before", 64'(tb_wr_en), 64'(1));
        reset = 1'b1;
        #1;
        chk("midrst_state", 64'(state), 64'(0));
        chk("midrst_wr_en", 64'(tb_wr_en), 64'(0));
        chk("midrst_ack", 64'(src_ack), 64'(0));
        chk("midrst_wrapped", 64'(wrapped), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, 4'hF, 0);
        chk("after_rst_trig_state", 64'(state), 64'(0));
        chk("after_rst_trig_wr", 64'(tb_wr_en), 64'(0));
        drive(0, 0, 4'hF, 0);
        chk("after_rst_idle", 64'(state), 64'(0));
        chk("after_rst_no_wr", 64'(tb_wr_en), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
